// File: rtl/rv_loader_pkg.sv
// Shared definitions for the byte-stream code loader.
// Provides the loader FSM state encoding, the default frame start byte and
// the byte offsets of the fixed frame header fields.
package rv_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CNT_LO = 3'd1,
    CNT_HI = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

  // Byte offsets inside a frame
  localparam int unsigned OFF_MAGIC  = 0;
  localparam int unsigned OFF_CNT_LO = 1;
  localparam int unsigned OFF_CNT_HI = 2;
  localparam int unsigned OFF_DATA   = 3;

  localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/rv_word_pack.sv
// Little-endian byte-to-word assembler.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   clr          drop any partial word and restart at byte 0
//   shift        accept byte_in into the word
//   byte_in      incoming byte
//   word_next_c  assembled word including byte_in (valid with done_c)
//   done_c       byte_in completes a word (4th byte)
module rv_word_pack (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        shift,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next_c,
  output logic        done_c
);

  logic [1:0]  idx;
  logic [23:0] acc;

  // Only the first three bytes need storing; the fourth arrives with done_c.
  assign word_next_c = {byte_in, acc};
  assign done_c      = shift && (idx == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= 2'd0;
      acc <= 24'd0;
    end else if (clr) begin
      idx <= 2'd0;
      acc <= 24'd0;
    end else if (shift) begin
      idx <= idx + 2'd1;
      acc <= {byte_in, acc[23:8]};
    end
  end

endmodule

// File: rtl/rv_code_loader.sv
// Framed byte-stream loader writing instruction memory one word per cycle.
// Frame: MAGIC, CNT_LO, CNT_HI, 4*CNT data bytes (LSB first), [CSUM].
// Optional feature macro LOADER_CSUM_EN: when defined a trailing XOR
// checksum byte is expected and checked; when undefined there is none.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   byte_valid   byte_data valid
//   byte_data    stream byte
//   byte_ready   loader accepts a byte (low during the write cycle)
//   imem_we      code memory write strobe
//   imem_addr    word address of the write
//   imem_wdata   write data
//   cpu_hold     hold request to the core
//   load_done    last frame accepted
//   load_err     last frame rejected
module rv_code_loader
  import rv_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 10,
  parameter int unsigned MEM_WORDS     = 1024,
  parameter logic [7:0]  MAGIC         = MAGIC_DEFAULT,
  parameter bit          HOLD_AT_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_err
);

  // One extra bit so a count of exactly MEM_WORDS does not wrap the index
  localparam int unsigned IDX_W = ADDR_WIDTH + 1;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   word_idx;

  logic               accept_c;
  logic               start_c;
  logic               pack_shift_c;
  logic [CNT_W-1:0]   cnt_full_c;
  logic               last_word_c;
  logic [31:0]        word_next_c;
  logic               word_done_c;

  assign accept_c     = byte_valid && byte_ready;
  assign start_c      = accept_c && (byte_data == MAGIC) &&
                        (state == IDLE || state == DONE || state == ERR);
  assign pack_shift_c = accept_c && (state == DATA);
  assign cnt_full_c   = {byte_data, cnt[7:0]};
  assign last_word_c  = (32'(word_idx) + 32'd1) == 32'(cnt);

  rv_word_pack u_pack (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (start_c),
    .shift       (pack_shift_c),
    .byte_in     (byte_data),
    .word_next_c (word_next_c),
    .done_c      (word_done_c)
  );

`ifdef LOADER_CSUM_EN
  logic [7:0] csum;

  // Running XOR over the count bytes and all data bytes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum <= 8'd0;
    end else if (start_c) begin
      csum <= 8'd0;
    end else if (accept_c && (state == CNT_LO || state == CNT_HI || state == DATA)) begin
      csum <= csum ^ byte_data;
    end
  end
`endif

  // Frame FSM with registered outputs; advances only on accepted bytes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      word_idx   <= '0;
      byte_ready <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      cpu_hold   <= HOLD_AT_RESET;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      imem_we    <= 1'b0;
      byte_ready <= 1'b1;
      if (accept_c) begin
        case (state)
          IDLE, DONE, ERR: begin
            if (byte_data == MAGIC) begin
              state     <= CNT_LO;
              cpu_hold  <= 1'b1;
              load_done <= 1'b0;
              load_err  <= 1'b0;
              word_idx  <= '0;
              cnt       <= '0;
            end
          end
          CNT_LO: begin
            cnt[7:0] <= byte_data;
            state    <= CNT_HI;
          end
          CNT_HI: begin
            cnt <= cnt_full_c;
            if (32'(cnt_full_c) > MEM_WORDS) begin
              state    <= ERR;
              load_err <= 1'b1;
            end else if (cnt_full_c == '0) begin
`ifdef LOADER_CSUM_EN
              state <= CSUM;
`else
              state     <= DONE;
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
`endif
            end else begin
              state <= DATA;
            end
          end
          DATA: begin
            if (word_done_c) begin
              imem_we    <= 1'b1;
              byte_ready <= 1'b0;
              imem_addr  <= word_idx[ADDR_WIDTH-1:0];
              imem_wdata <= word_next_c;
              word_idx   <= word_idx + IDX_W'(1);
              if (last_word_c) begin
`ifdef LOADER_CSUM_EN
                state <= CSUM;
`else
                state     <= DONE;
                load_done <= 1'b1;
                cpu_hold  <= 1'b0;
`endif
              end
            end
          end
`ifdef LOADER_CSUM_EN
          CSUM: begin
            if (byte_data == csum) begin
              state     <= DONE;
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              state    <= ERR;
              load_err <= 1'b1;
            end
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rv_code_loader.sv
// Directed bench for rv_code_loader: frames with hand-computed results.
// Expectations that depend on LOADER_CSUM_EN are selected with the same macro.
module tb_rv_code_loader;

  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = 8'd0;
  logic          byte_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic          load_err;

  rv_code_loader #(
    .ADDR_WIDTH    (AW),
    .MEM_WORDS     (1024),
    .MAGIC         (8'hA5),
    .HOLD_AT_RESET (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int stalls = 0;
  int b2b    = 0;
  int rdy_bad = 0;
  logic prev_we = 1'b0;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [7:0]  fr[$];

  // Write-port monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (imem_we) begin
      wa_q.push_back(32'(imem_addr));
      wd_q.push_back(imem_wdata);
      if (prev_we) b2b++;
      if (byte_ready) rdy_bad++;
    end
    prev_we = imem_we;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one byte and hold it until accepted (bounded)
  task automatic send_byte(input logic [7:0] b);
    logic r;
    logic ok;
    ok = 1'b0;
    byte_data  = b;
    byte_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      r = byte_ready;
      @(posedge clk);
      #1;
      if (r) begin
        ok = 1'b1;
        break;
      end
      stalls++;
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame();
    stalls = 0;
    wa_q.delete();
    wd_q.delete();
    foreach (fr[i]) send_byte(fr[i]);
    byte_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string tag, input logic d, input logic e, input logic h);
    check({tag, "_done"}, 32'(load_done), 32'(d));
    check({tag, "_err"},  32'(load_err),  32'(e));
    check({tag, "_hold"}, 32'(cpu_hold),  32'(h));
  endtask

  task automatic check_good_writes(input string tag);
    check({tag, "_nwr"}, 32'(wa_q.size()), 32'd2);
    if (wa_q.size() == 2) begin
      check({tag, "_a0"}, wa_q[0], 32'd0);
      check({tag, "_d0"}, wd_q[0], 32'h0000_0013);
      check({tag, "_a1"}, wa_q[1], 32'd1);
      check({tag, "_d1"}, wd_q[1], 32'h0010_0093);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(byte_ready), 32'd1);
    check({tag, "_we"},    32'(imem_we),    32'd0);
    check({tag, "_addr"},  32'(imem_addr),  32'd0);
    check({tag, "_wdata"}, imem_wdata,      32'd0);
    check_flags(tag, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Good 2-word frame preceded by a stray byte; trailing 0x92 is the checksum
    send_byte(8'h11);
    fr = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
           8'h93, 8'h00, 8'h10, 8'h00, 8'h92};
    send_frame();
    check_good_writes("good");
    check_flags("good", 1'b1, 1'b0, 1'b0);
    check("good_stalls", 32'(stalls), 32'd2);

    // Same frame with a wrong checksum
    fr = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
           8'h93, 8'h00, 8'h10, 8'h00, 8'h93};
    send_frame();
    check_good_writes("badsum");
`ifdef LOADER_CSUM_EN
    check_flags("badsum", 1'b0, 1'b1, 1'b1);
`else
    check_flags("badsum", 1'b1, 1'b0, 1'b0);
`endif

    // Oversize count 1025
    fr = '{8'hA5, 8'h01, 8'h04};
    send_frame();
    check("big_nwr", 32'(wa_q.size()), 32'd0);
    check_flags("big", 1'b0, 1'b1, 1'b1);

    // Zero-word frame
    fr = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_frame();
    check("zero_nwr", 32'(wa_q.size()), 32'd0);
    check_flags("zero", 1'b1, 1'b0, 1'b0);

    // Reset after the 6th byte of a frame
    fr = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00};
    send_frame();
    check("mid_hold", 32'(cpu_hold), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    fr = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
           8'h93, 8'h00, 8'h10, 8'h00, 8'h92};
    send_frame();
    check_good_writes("after");
    check_flags("after", 1'b1, 1'b0, 1'b0);

    // New MAGIC after DONE re-asserts hold
    send_byte(8'hA5);
    byte_valid = 1'b0;
    check_flags("remagic", 1'b0, 1'b0, 1'b1);

    check("no_b2b_we", 32'(b2b), 32'd0);
    check("ready_low_on_we", 32'(rdy_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
